// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks destination registers of the three instructions
// downstream of decode (RF, ALU, MEM), stalls decode on a read-after-write
// conflict and inserts bubbles for a fixed number of cycles after a taken branch.
module hazard_ctrl #(
   parameter int                    CODE_SIZE    = 6,
   parameter int                    REG_SIZE     = 5,
   parameter logic [CODE_SIZE-1:0]  STORE_CODE   = 6'h2B,
   parameter logic [CODE_SIZE-1:0]  BRANCH_CODE  = 6'h04,
   parameter int                    FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CODE_SIZE-1:0] id_icode,
   input  logic [REG_SIZE-1:0]  id_ri,
   input  logic [REG_SIZE-1:0]  id_rj,
   input  logic [REG_SIZE-1:0]  id_rk,
   input  logic                 flush,
   output logic                 pc_enable,
   output logic                 id_hold,
   output logic                 rf_bubble,
   output logic [15:0]          stall_cnt
);

   typedef enum logic {RUN, FLUSH} state_t;

   // Counter reload value; FLUSH_CYCLES is expected in 1..3 so it fits 2 bits.
   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [1:0]          cnt_reg, cnt_next;
   logic [2:0]          valid_reg;
   logic [REG_SIZE-1:0] dest_reg [3];

   logic [2:0]          match_j, match_k;
   logic                hazard;
   logic                writes;
   logic                stall;

   // Per-entry source comparators, one pair per tracked stage.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_match
         assign match_j[gi] = valid_reg[gi] && (dest_reg[gi] == id_rj);
         assign match_k[gi] = valid_reg[gi] && (dest_reg[gi] == id_rk);
      end
   endgenerate

   // Register 0 is hardwired, so neither a zero source nor a zero destination
   // can create a dependency; nops never stall.
   assign hazard = (id_icode != '0) &&
                   (((id_rj != '0) && (|match_j)) ||
                    ((id_rk != '0) && (|match_k)));

   // Stores and branches carry register fields but write nothing back.
   assign writes = (id_icode != '0) &&
                   (id_icode != STORE_CODE) &&
                   (id_icode != BRANCH_CODE) &&
                   (id_ri != '0);

   // Next-state and output decode; flush wins over a hazard in RUN.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pc_enable  = 1'b1;
      id_hold    = 1'b0;
      rf_bubble  = 1'b0;
      stall      = 1'b0;
      case (state_reg)
         RUN: begin
            if (flush) begin
               state_next = FLUSH;
               cnt_next   = FLUSH_LOAD;
            end else if (hazard) begin
               pc_enable = 1'b0;
               id_hold   = 1'b1;
               rf_bubble = 1'b1;
               stall     = 1'b1;
            end
         end
         FLUSH: begin
            rf_bubble = 1'b1;
            if (flush) begin
               cnt_next = FLUSH_LOAD;
            end else if (cnt_reg == 2'd0) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end
         default: begin
            state_next = RUN;
            cnt_next   = 2'd0;
         end
      endcase
   end

   // State and flush counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RUN;
         cnt_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Destination tracker: shifts one stage per cycle; the decode instruction
   // enters RF only when it actually issues, writes, and is not being flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
         for (int i = 0; i < 3; i++) begin
            dest_reg[i] <= '0;
         end
      end else begin
         valid_reg[2] <= valid_reg[1];
         dest_reg[2]  <= dest_reg[1];
         valid_reg[1] <= valid_reg[0];
         dest_reg[1]  <= dest_reg[0];
         if (!flush && !rf_bubble && writes) begin
            valid_reg[0] <= 1'b1;
            dest_reg[0]  <= id_ri;
         end else begin
            valid_reg[0] <= 1'b0;
            dest_reg[0]  <= '0;
         end
      end
   end

   // Saturating count of hazard-stall cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CODE_SIZE, default 6, opcode width.
REQ-002 Parameter REG_SIZE, default 5, register-index width.
REQ-003 Parameter STORE_CODE, default 6'h2B, opcode that writes no register.
REQ-004 Parameter BRANCH_CODE, default 6'h04, opcode that writes no register.
REQ-005 Parameter FLUSH_CYCLES, default 2, bubble cycles after a flush; range 1..3.
REQ-006 Ports: one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 id_icode  input  CODE_SIZE  opcode held at decode-register output; 0 = nop.
REQ-010 id_ri / id_rj / id_rk  input  REG_SIZE each  destination / source-1 / source-2 of the decode instruction.
REQ-011 flush  input  1  single-cycle pulse; branch taken in ALU stage.
REQ-012 pc_enable  output  1  1 = PC advances.
REQ-013 id_hold  output  1  1 = decode register keeps its contents.
REQ-014 rf_bubble  output  1  1 = nop loaded into RF stage instead of the decode instruction.
REQ-015 stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-016 Tracker: 3 entries E0 (RF), E1 (ALU), E2 (MEM), each {valid, dest[REG_SIZE-1:0]}.
REQ-017 Decode instruction writes iff id_icode != 0, id_icode not STORE_CODE or BRANCH_CODE, and id_ri != 0.
REQ-018 Hazard when id_icode != 0 and (id_rj != 0 matches dest of any valid entry, or id_rk != 0 matches dest of any valid entry).
REQ-019 Register 0 never causes a hazard.
REQ-020 FSM states: RUN, FLUSH.
REQ-021 RUN, no hazard: pc_enable=1, id_hold=0, rf_bubble=0.
REQ-022 RUN, hazard: pc_enable=0, id_hold=1, rf_bubble=1.
REQ-023 FLUSH: pc_enable=1, id_hold=0, rf_bubble=1; hazard is ignored.
REQ-024 Outputs are combinational from state, tracker and inputs; no added latency.
REQ-025 Each edge, E2<=E1 and E1<=E0.
REQ-026 Each edge, E0<={1,id_ri} if rf_bubble=0 and the instruction writes; otherwise E0<={0,0}.
REQ-027 Stall length is self-limiting: at most 3 consecutive cycles, because the blocking entry shifts out.
REQ-028 flush=1 in any state: at that edge E0 is invalidated, FSM enters FLUSH, and the flush counter loads FLUSH_CYCLES-1.
REQ-029 Flush has priority over hazard in the same cycle; outputs that cycle are as in RUN.
REQ-030 FLUSH decrements its counter each cycle and returns to RUN in the cycle after the counter reads 0.
REQ-031 flush during FLUSH reloads the counter (retrigger).
REQ-032 stall_cnt increments on each edge where REQ-022 outputs are active.
REQ-033 stall_cnt holds at 16'hFFFF; no wrap-around.

Reset
REQ-034 rst=1 forces all entries invalid, state RUN, flush counter 0 and stall_cnt 0 immediately, independent of clk.
REQ-035 During and after reset with an empty tracker, outputs are pc_enable=1, id_hold=0, rf_bubble=0.
REQ-036 Reset mid-stall or mid-flush takes effect immediately; the first edge after release behaves as RUN with an empty tracker.

Verification
REQ-037 RAW distance 1: decode icode=1 ri=3; next decode rj=3 -> 3 stall cycles (pc_enable=0, id_hold=1, rf_bubble=1), then release; stall_cnt=3.
REQ-038 RAW distance 2: writer of r5, one independent instruction, then reader rk=5 -> exactly 2 stall cycles.
REQ-039 Register 0 and store: writer ri=0 or icode=STORE_CODE, then reader rj=0 or rj equal to that ri -> no stall; stall_cnt unchanged.
REQ-040 Flush: flush pulse with FLUSH_CYCLES=2 -> rf_bubble=1 with pc_enable=1 for 2 cycles; E0 writer's dest no longer causes a hazard.
REQ-041 Flush coinciding with hazard, then a second flush during FLUSH -> no stall counted; FLUSH extended by a full FLUSH_CYCLES.
REQ-042 Saturation and reset: preload stall_cnt to 16'hFFFE, force 3 stalls -> 16'hFFFF held; assert rst mid-stall -> outputs 1/0/0 and stall_cnt=0 asynchronously.
